// File: rtl/wdat_pkg.sv
// Shared state encodings and default geometry for the write-data line assembler.
package wdat_pkg;

   localparam int unsigned DefDw    = 32;
   localparam int unsigned DefBeats = 4;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StBinp = 2'b01,
      StDrop = 2'b10,
      StHold = 2'b11
   } wdat_state_e;

endpackage

// File: rtl/wdat_line_buf.sv
// Line buffer: BEATS slots of data plus byte mask, with clear-all and one-slot write.
module wdat_line_buf #(
   parameter int unsigned DW    = 32,
   parameter int unsigned BEATS = 4,
   parameter int unsigned CW    = $clog2(BEATS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr_i,
   input  logic                  we_i,
   input  logic [CW-1:0]         idx_i,
   input  logic [DW-1:0]         data_i,
   input  logic [DW/8-1:0]       strb_i,
   output logic [DW*BEATS-1:0]   line_data_o,
   output logic [DW/8*BEATS-1:0] line_mask_o
);

   localparam int unsigned MW = DW / 8;

   logic [DW-1:0] data_q [BEATS];
   logic [DW-1:0] data_d [BEATS];
   logic [MW-1:0] mask_q [BEATS];
   logic [MW-1:0] mask_d [BEATS];

   always_comb begin
      for (int k = 0; k < BEATS; k++) begin
         data_d[k] = data_q[k];
         mask_d[k] = mask_q[k];
      end
      if (clr_i) begin
         for (int k = 0; k < BEATS; k++) begin
            data_d[k] = '0;
            mask_d[k] = '0;
         end
      end else if (we_i) begin
         data_d[idx_i] = data_i;
         mask_d[idx_i] = strb_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < BEATS; k++) begin
            data_q[k] <= '0;
            mask_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < BEATS; k++) begin
            data_q[k] <= data_d[k];
            mask_q[k] <= mask_d[k];
         end
      end
   end

   always_comb begin
      line_data_o = '0;
      line_mask_o = '0;
      for (int k = 0; k < BEATS; k++) begin
         line_data_o[k*DW +: DW] = data_q[k];
         line_mask_o[k*MW +: MW] = mask_q[k];
      end
   end

endmodule

// File: rtl/wdata_chan_subo_par.sv
// AXI W-channel burst assembler: collects beats into one line, drops overflow beats,
// and presents the line downstream with a valid/ready handshake.
module wdata_chan_subo_par
   import wdat_pkg::*;
#(
   parameter int unsigned DW    = DefDw,
   parameter int unsigned BEATS = DefBeats,
   parameter int unsigned CW    = $clog2(BEATS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  next_srq,
   input  logic                  wvalid,
   output logic                  wready,
   input  logic [DW-1:0]         wdata,
   input  logic [DW/8-1:0]       wstrb,
   input  logic                  wlast,
   output logic [DW*BEATS-1:0]   wdat_s_data,
   output logic [DW/8*BEATS-1:0] wdat_s_mask,
   output logic [CW:0]           wdat_s_beats,
   output logic                  wdat_s_valid,
   input  logic                  wdat_s_ready,
   output logic                  finish_swd,
   output logic                  werr
);

   localparam logic [CW:0] LastSlot = (CW+1)'(BEATS - 1);

   wdat_state_e state_q, state_d;
   logic [CW:0] cntr_q, cntr_d;
   logic        werr_q, werr_d;
   logic        buf_clr, buf_we;

   always_comb begin
      state_d      = state_q;
      cntr_d       = cntr_q;
      werr_d       = werr_q;
      buf_clr      = 1'b0;
      buf_we       = 1'b0;
      wready       = 1'b0;
      wdat_s_valid = 1'b0;
      finish_swd   = 1'b0;
      case (state_q)
         StIdle: begin
            if (next_srq) begin
               state_d = StBinp;
               cntr_d  = '0;
               buf_clr = 1'b1;
            end
         end
         StBinp: begin
            wready = 1'b1;
            if (wvalid) begin
               buf_we = 1'b1;
               cntr_d = cntr_q + 1'b1;
               if (wlast) begin
                  state_d = StHold;
               end else if (cntr_q == LastSlot) begin
                  state_d = StDrop;
               end
            end
         end
         StDrop: begin
            wready = 1'b1;
            if (wvalid) begin
               werr_d = 1'b1;
               if (wlast) begin
                  state_d = StHold;
               end
            end
         end
         StHold: begin
            wdat_s_valid = 1'b1;
            if (wdat_s_ready) begin
               finish_swd = 1'b1;
               if (next_srq) begin
                  state_d = StBinp;
                  cntr_d  = '0;
                  buf_clr = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cntr_q  <= '0;
         werr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cntr_q  <= cntr_d;
         werr_q  <= werr_d;
      end
   end

   assign wdat_s_beats = cntr_q;
   assign werr         = werr_q;

   wdat_line_buf #(
      .DW    (DW),
      .BEATS (BEATS),
      .CW    (CW)
   ) u_line_buf (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (buf_clr),
      .we_i        (buf_we),
      .idx_i       (cntr_q[CW-1:0]),
      .data_i      (wdata),
      .strb_i      (wstrb),
      .line_data_o (wdat_s_data),
      .line_mask_o (wdat_s_mask)
   );

endmodule
